memory_stage: RTL and testbench

- Consumer end of the execute-stage result interface.
- Registers EX results, performs the data-memory access through a valid/ready handshake, and produces registered write-back results.
- Stalls the upstream pipeline while a memory access is outstanding.
- Reports misaligned, illegal and timed-out accesses.

---
 rtl/memory_stage_pkg.sv | 27 ++
 rtl/mem_wait_timer.sv | 32 +++
 rtl/memory_stage.sv | 156 +++++++++++++++
 tb/tb_memory_stage.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// Shared types and constants for the memory stage: FSM states, the captured
// MEM-op control bundle and the word-alignment mask.
package memory_stage_pkg;

  localparam int MEM_REG_W = 5;

  // Any set bit under this mask makes a word access misaligned.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef struct packed {
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 mem_to_reg;
    logic [MEM_REG_W-1:0] write_reg;
  } mem_ctrl_t;

  function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
    return |(addr_lsbs & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request has waited; expired flags the final allowed
// wait cycle so the stage can abandon the access on the following edge.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // NOTE: state registers use non-blocking (<=) assignments and take the
  // asynchronous reset, so every flop powers up in a known value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: accepts EX results, runs the data-memory handshake with
// a wait timeout, and emits registered write-back results and fault pulses.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int REG_W          = MEM_REG_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ExValid,
  input  logic [DATA_W-1:0] ALUOutIn,
  input  logic [DATA_W-1:0] ReadData2In,
  input  logic              RegWriteIn,
  input  logic              MemReadIn,
  input  logic              MemWriteIn,
  input  logic              MemToRegIn,
  input  logic [REG_W-1:0]  WriteRegIn,
  output logic              StallOut,
  output logic              DMemReq,
  output logic              DMemWe,
  output logic [DATA_W-1:0] DMemAddr,
  output logic [DATA_W-1:0] DMemWData,
  input  logic              DMemReady,
  input  logic [DATA_W-1:0] DMemRData,
  output logic              WBValid,
  output logic              WBRegWrite,
  output logic [REG_W-1:0]  WBWriteReg,
  output logic [DATA_W-1:0] WBData,
  output logic              MemFault
);

  state_t            state, state_nxt;
  mem_ctrl_t         ctrl_q;
  logic [DATA_W-1:0] addr_q, wdata_q;

  logic              is_mem, illegal, start_access, expired;

  logic              wb_valid_nxt, wb_reg_write_nxt, fault_nxt;
  logic [REG_W-1:0]  wb_write_reg_nxt;
  logic [DATA_W-1:0] wb_data_nxt;

  assign is_mem       = MemReadIn | MemWriteIn;
  assign illegal      = (MemReadIn & MemWriteIn) | is_misaligned(ALUOutIn[1:0]);
  assign start_access = (state == IDLE) && ExValid && is_mem && !illegal;

  mem_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state != ACCESS),
    .enable  ((state == ACCESS) && !DMemReady),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt        = state;
    wb_valid_nxt     = 1'b0;
    wb_reg_write_nxt = 1'b0;
    fault_nxt        = 1'b0;
    wb_write_reg_nxt = WBWriteReg;
    wb_data_nxt      = WBData;

    case (state)
      IDLE: begin
        if (ExValid) begin
          if (!is_mem) begin
            wb_valid_nxt     = 1'b1;
            wb_reg_write_nxt = RegWriteIn && (WriteRegIn != '0);
            wb_write_reg_nxt = WriteRegIn;
            wb_data_nxt      = ALUOutIn;
          end else if (illegal) begin
            wb_valid_nxt     = 1'b1;
            fault_nxt        = 1'b1;
            wb_write_reg_nxt = WriteRegIn;
            wb_data_nxt      = ALUOutIn;
          end else begin
            state_nxt = ACCESS;
          end
        end
      end

      ACCESS: begin
        // A ready in the last allowed cycle still completes the access.
        if (DMemReady) begin
          state_nxt        = IDLE;
          wb_valid_nxt     = 1'b1;
          wb_reg_write_nxt = ctrl_q.reg_write && ctrl_q.mem_read &&
                             (ctrl_q.write_reg != '0);
          wb_write_reg_nxt = ctrl_q.write_reg;
          wb_data_nxt      = (ctrl_q.mem_read && ctrl_q.mem_to_reg) ? DMemRData : addr_q;
        end else if (expired) begin
          state_nxt        = IDLE;
          wb_valid_nxt     = 1'b1;
          fault_nxt        = 1'b1;
          wb_write_reg_nxt = ctrl_q.write_reg;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured once at acceptance and held through ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (start_access) begin
      ctrl_q  <= '{reg_write:  RegWriteIn,
                   mem_read:   MemReadIn,
                   mem_write:  MemWriteIn,
                   mem_to_reg: MemToRegIn,
                   write_reg:  WriteRegIn};
      addr_q  <= ALUOutIn;
      wdata_q <= ReadData2In;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WBValid    <= 1'b0;
      WBRegWrite <= 1'b0;
      WBWriteReg <= '0;
      WBData     <= '0;
      MemFault   <= 1'b0;
    end else begin
      WBValid    <= wb_valid_nxt;
      WBRegWrite <= wb_reg_write_nxt;
      WBWriteReg <= wb_write_reg_nxt;
      WBData     <= wb_data_nxt;
      MemFault   <= fault_nxt;
    end
  end

  // Derived from state so an asynchronous reset drops the request at once.
  assign StallOut  = (state == ACCESS);
  assign DMemReq   = (state == ACCESS);
  assign DMemWe    = ctrl_q.mem_write;
  assign DMemAddr  = addr_q;
  assign DMemWData = wdata_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios with literal
// expectations, then randomized traffic compared against a transaction model.
module tb_memory_stage;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ExValid = 1'b0;
  logic [DATA_W-1:0] ALUOutIn = '0;
  logic [DATA_W-1:0] ReadData2In = '0;
  logic              RegWriteIn = 1'b0;
  logic              MemReadIn = 1'b0;
  logic              MemWriteIn = 1'b0;
  logic              MemToRegIn = 1'b0;
  logic [REG_W-1:0]  WriteRegIn = '0;
  logic              StallOut, DMemReq, DMemWe;
  logic [DATA_W-1:0] DMemAddr, DMemWData;
  logic              DMemReady = 1'b0;
  logic [DATA_W-1:0] DMemRData = '0;
  logic              WBValid, WBRegWrite, MemFault;
  logic [REG_W-1:0]  WBWriteReg;
  logic [DATA_W-1:0] WBData;

  int n_checks = 0;
  int n_pass   = 0;

  memory_stage #(
    .DATA_W         (DATA_W),
    .REG_W          (REG_W),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ExValid     (ExValid),
    .ALUOutIn    (ALUOutIn),
    .ReadData2In (ReadData2In),
    .RegWriteIn  (RegWriteIn),
    .MemReadIn   (MemReadIn),
    .MemWriteIn  (MemWriteIn),
    .MemToRegIn  (MemToRegIn),
    .WriteRegIn  (WriteRegIn),
    .StallOut    (StallOut),
    .DMemReq     (DMemReq),
    .DMemWe      (DMemWe),
    .DMemAddr    (DMemAddr),
    .DMemWData   (DMemWData),
    .DMemReady   (DMemReady),
    .DMemRData   (DMemRData),
    .WBValid     (WBValid),
    .WBRegWrite  (WBRegWrite),
    .WBWriteReg  (WBWriteReg),
    .WBData      (WBData),
    .MemFault    (MemFault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: one pending access at most, plus how many
  // request cycles it has already gone unanswered.
  bit                busy = 0;
  int                waited = 0;
  logic [DATA_W-1:0] p_addr = '0, p_wdata = '0;
  bit                p_rw = 0, p_rd = 0, p_wr = 0, p_m2r = 0;
  logic [REG_W-1:0]  p_dst = '0;
  bit                e_wb_valid = 0, e_fault = 0, e_wb_rw = 0, e_data_chk = 0;
  logic [REG_W-1:0]  e_wb_reg = '0;
  logic [DATA_W-1:0] e_wb_data = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy = 0; waited = 0;
      e_wb_valid = 0; e_fault = 0; e_wb_rw = 0; e_data_chk = 0;
      e_wb_reg = '0; e_wb_data = '0;
      p_addr = '0; p_wdata = '0; p_wr = 0;
    end else begin
      e_wb_valid = 0; e_fault = 0; e_wb_rw = 0; e_data_chk = 0;
      if (busy) begin
        if (DMemReady) begin
          busy = 0;
          e_wb_valid = 1;
          e_wb_reg   = p_dst;
          e_wb_rw    = p_rd && p_rw && (p_dst != 0);
          if (p_rd) begin
            e_data_chk = 1;
            e_wb_data  = p_m2r ? DMemRData : p_addr;
          end
        end else if (waited + 1 == TIMEOUT) begin
          busy = 0;
          e_wb_valid = 1;
          e_fault    = 1;
          e_wb_reg   = p_dst;
        end else begin
          waited++;
        end
      end else if (ExValid) begin
        if (!MemReadIn && !MemWriteIn) begin
          e_wb_valid = 1;
          e_wb_reg   = WriteRegIn;
          e_wb_rw    = RegWriteIn && (WriteRegIn != 0);
          e_data_chk = 1;
          e_wb_data  = ALUOutIn;
        end else if ((MemReadIn && MemWriteIn) || (ALUOutIn % 4 != 0)) begin
          e_wb_valid = 1;
          e_fault    = 1;
          e_wb_reg   = WriteRegIn;
        end else begin
          busy = 1; waited = 0;
          p_addr = ALUOutIn; p_wdata = ReadData2In;
          p_rw = RegWriteIn; p_rd = MemReadIn; p_wr = MemWriteIn; p_m2r = MemToRegIn;
          p_dst = WriteRegIn;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("StallOut", StallOut, busy);
    check("DMemReq", DMemReq, busy);
    if (busy) begin
      check("DMemAddr", DMemAddr, p_addr);
      check("DMemWData", DMemWData, p_wdata);
      check("DMemWe", DMemWe, p_wr);
    end
    check("WBValid", WBValid, e_wb_valid);
    check("MemFault", MemFault, e_fault);
    check("WBRegWrite", WBRegWrite, e_wb_rw);
    check("WBWriteReg", WBWriteReg, e_wb_reg);
    if (e_wb_valid && e_data_chk) check("WBData", WBData, e_wb_data);
  end

  task automatic drive_op(input logic [31:0] alu, input logic [31:0] rd2, input bit rw,
                          input bit mr, input bit mw, input bit m2r, input logic [4:0] dst);
    ExValid = 1'b1; ALUOutIn = alu; ReadData2In = rd2; RegWriteIn = rw;
    MemReadIn = mr; MemWriteIn = mw; MemToRegIn = m2r; WriteRegIn = dst;
  endtask

  task automatic idle_inputs();
    ExValid = 1'b0; RegWriteIn = 1'b0; MemReadIn = 1'b0; MemWriteIn = 1'b0; MemToRegIn = 1'b0;
  endtask

  initial begin
    int pct;
    int kind;

    #1;
    check("rst StallOut", StallOut, 0);
    check("rst DMemReq", DMemReq, 0);
    check("rst DMemWe", DMemWe, 0);
    check("rst WBValid", WBValid, 0);
    check("rst WBRegWrite", WBRegWrite, 0);
    check("rst MemFault", MemFault, 0);
    check("rst DMemAddr", DMemAddr, 0);
    check("rst DMemWData", DMemWData, 0);
    check("rst WBWriteReg", WBWriteReg, 0);
    check("rst WBData", WBData, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU op writes x5.
    @(negedge clk);
    drive_op(32'h1234, 32'h0, 1, 0, 0, 0, 5'd5);
    @(posedge clk); #1;
    check("alu WBValid", WBValid, 1);
    check("alu WBData", WBData, 32'h1234);
    check("alu WBRegWrite", WBRegWrite, 1);
    check("alu WBWriteReg", WBWriteReg, 5);
    check("alu StallOut", StallOut, 0);

    // ALU op targeting x0 never writes.
    @(negedge clk);
    drive_op(32'h55, 32'h0, 1, 0, 0, 0, 5'd0);
    @(posedge clk); #1;
    check("x0 WBValid", WBValid, 1);
    check("x0 WBRegWrite", WBRegWrite, 0);

    // Load at 0x100, memory answers in the third request cycle.
    @(negedge clk);
    drive_op(32'h100, 32'h0, 1, 1, 0, 1, 5'd7);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("ld DMemReq", DMemReq, 1);
      check("ld StallOut", StallOut, 1);
      check("ld DMemAddr", DMemAddr, 32'h100);
      check("ld DMemWe", DMemWe, 0);
      @(negedge clk);
      idle_inputs();
      if (i == 2) begin DMemReady = 1'b1; DMemRData = 32'hDEADBEEF; end
    end
    @(posedge clk); #1;
    check("ld DMemReq done", DMemReq, 0);
    check("ld WBValid", WBValid, 1);
    check("ld WBData", WBData, 32'hDEADBEEF);
    check("ld WBRegWrite", WBRegWrite, 1);
    @(negedge clk);
    DMemReady = 1'b0;

    // Store at 0x204, ready on the first request cycle.
    drive_op(32'h204, 32'hA5A5A5A5, 0, 0, 1, 0, 5'd3);
    @(posedge clk); #1;
    check("st DMemWe", DMemWe, 1);
    check("st DMemWData", DMemWData, 32'hA5A5A5A5);
    check("st DMemAddr", DMemAddr, 32'h204);
    @(negedge clk);
    idle_inputs();
    DMemReady = 1'b1;
    @(posedge clk); #1;
    check("st WBValid", WBValid, 1);
    check("st WBRegWrite", WBRegWrite, 0);
    @(negedge clk);
    DMemReady = 1'b0;

    // Misaligned load, then simultaneous read+write.
    drive_op(32'h102, 32'h0, 1, 1, 0, 1, 5'd4);
    @(posedge clk); #1;
    check("mis DMemReq", DMemReq, 0);
    check("mis MemFault", MemFault, 1);
    check("mis WBValid", WBValid, 1);
    check("mis WBRegWrite", WBRegWrite, 0);
    @(negedge clk);
    drive_op(32'h200, 32'h0, 1, 1, 1, 1, 5'd4);
    @(posedge clk); #1;
    check("rw DMemReq", DMemReq, 0);
    check("rw MemFault", MemFault, 1);
    check("rw WBRegWrite", WBRegWrite, 0);
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    check("fault pulse width", MemFault, 0);

    // Load that is never answered: four request cycles, then a fault.
    @(negedge clk);
    drive_op(32'h300, 32'h0, 1, 1, 0, 1, 5'd9);
    for (int i = 0; i < TIMEOUT; i++) begin
      @(posedge clk); #1;
      check("to DMemReq", DMemReq, 1);
      @(negedge clk);
      idle_inputs();
    end
    @(posedge clk); #1;
    check("to DMemReq drop", DMemReq, 0);
    check("to MemFault", MemFault, 1);
    check("to WBValid", WBValid, 1);
    check("to WBRegWrite", WBRegWrite, 0);
    check("to StallOut", StallOut, 0);

    // Reset in the middle of an access.
    @(negedge clk);
    drive_op(32'h40, 32'h0, 1, 1, 0, 1, 5'd2);
    @(posedge clk); #1;
    check("rs DMemReq before", DMemReq, 1);
    @(negedge clk);
    idle_inputs();
    #1 rst_n = 1'b0;
    #1;
    check("rs DMemReq async", DMemReq, 0);
    check("rs StallOut async", StallOut, 0);
    @(negedge clk);
    rst_n = 1'b1;
    DMemReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rs no WBValid", WBValid, 0);
      check("rs no MemFault", MemFault, 0);
    end

    // Randomized traffic under three memory responsiveness levels.
    for (int seg = 0; seg < 3; seg++) begin
      pct = (seg == 0) ? 60 : (seg == 1) ? 15 : 90;
      repeat (700) begin
        @(negedge clk);
        DMemReady = ($urandom_range(99) < pct);
        DMemRData = $urandom;
        if (!StallOut) begin
          ExValid     = ($urandom_range(99) < 75);
          kind        = $urandom_range(9);
          ALUOutIn    = $urandom;
          if ($urandom_range(7) != 0) ALUOutIn[1:0] = 2'b00;
          ReadData2In = $urandom;
          RegWriteIn  = $urandom_range(1);
          MemToRegIn  = $urandom_range(1);
          WriteRegIn  = REG_W'($urandom_range(31));
          MemReadIn   = (kind >= 4 && kind <= 6) || kind == 9;
          MemWriteIn  = (kind == 7 || kind == 8) || kind == 9;
        end
      end
    end

    @(negedge clk);
    idle_inputs();
    DMemReady = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
